// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and the byte-merge helper for the
// data-memory responder (dmem_resp) and its write buffer (dmem_wbuf).
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } resp_state_t;

  // Byte lane n of the result comes from new_word when mask[n] is set,
  // otherwise from old_word.
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [MASK_W-1:0] mask
  );
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MASK_W; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: one-entry posted write buffer with store-to-load forwarding.
//   i_clk, i_rst_n     : clock, synchronous active-low reset (drops the entry)
//   i_load             : accepted in-range store; captures idx/data/mask
//   i_idx/i_wdata/i_mask : store being posted
//   i_rd_idx, i_rd_word: word index and raw array word of the current load
//   o_rd_word          : load word with the pending entry merged in
//   o_cmt_*            : commit port toward the array, valid while entry held
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [MASK_W-1:0] i_mask,
  input  logic [AW-1:0]     i_rd_idx,
  input  logic [WORD_W-1:0] i_rd_word,
  output logic [WORD_W-1:0] o_rd_word,
  output logic              o_cmt_en,
  output logic [AW-1:0]     o_cmt_idx,
  output logic [WORD_W-1:0] o_cmt_data,
  output logic [MASK_W-1:0] o_cmt_mask
);

  logic              vld_q, vld_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [MASK_W-1:0] mask_q, mask_d;

  always_comb begin
    vld_d  = i_load;
    idx_d  = idx_q;
    data_d = data_q;
    mask_d = mask_q;
    if (i_load) begin
      idx_d  = i_idx;
      data_d = i_wdata;
      mask_d = i_mask;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) vld_q <= 1'b0;
    else          vld_q <= vld_d;
  end

  always_ff @(posedge i_clk) begin
    idx_q  <= idx_d;
    data_q <= data_d;
    mask_q <= mask_d;
  end

  // A reset edge must not commit the pending entry.
  assign o_cmt_en   = vld_q & i_rst_n;
  assign o_cmt_idx  = idx_q;
  assign o_cmt_data = data_q;
  assign o_cmt_mask = mask_q;

  assign o_rd_word = (vld_q && (idx_q == i_rd_idx))
                   ? byte_merge(i_rd_word, data_q, mask_q) : i_rd_word;

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder. Word-aligned loads (combinational data)
// and byte-masked stores; optional posted write buffer; clear sweep after
// reset.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_dmem_addr    : byte address, word index = addr[AW+1:2]
//   i_dmem_ren/wen : load/store request
//   i_dmem_wdata, i_dmem_mask : lane-aligned store data and byte enables
//   o_dmem_rdata   : load word (0 when not ready, no load, or out of range)
//   o_dmem_ready   : requests accepted
//   o_oob          : one-cycle pulse after an accepted out-of-range request
// Build option: DMEM_RESP_WBUF_EN enables the posted write buffer.
//
// state | meaning
// CLEAR | zeroing array word clr_idx_q per cycle, requests ignored
// IDLE  | accepting loads and stores
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int INIT_CLEAR = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_dmem_addr,
  input  logic              i_dmem_ren,
  input  logic              i_dmem_wen,
  input  logic [WORD_W-1:0] i_dmem_wdata,
  input  logic [MASK_W-1:0] i_dmem_mask,
  output logic [WORD_W-1:0] o_dmem_rdata,
  output logic              o_dmem_ready,
  output logic              o_oob
);

  localparam int AW = $clog2(DEPTH);

  resp_state_t       state_q, state_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;
  logic              clr_we;
  logic              oob_q, oob_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              req_acc, in_range, st_acc;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] rd_raw, rd_word;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [WORD_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic              unused_addr;

  assign unused_addr  = ^i_dmem_addr[1:0];
  assign o_dmem_ready = (state_q == IDLE);
  assign req_acc      = (i_dmem_ren | i_dmem_wen) & o_dmem_ready;
  assign in_range     = (i_dmem_addr[31:AW+2] == '0);
  assign idx          = i_dmem_addr[AW+1:2];
  assign st_acc       = req_acc & i_dmem_wen & in_range;
  assign rd_raw       = mem_q[idx];

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: ;
    endcase
  end

  assign oob_d = req_acc & ~in_range;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      clr_idx_q <= '0;
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      oob_q     <= oob_d;
    end
  end

`ifdef DMEM_RESP_WBUF_EN
  dmem_wbuf #(.AW(AW)) u_wbuf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (st_acc),
    .i_idx      (idx),
    .i_wdata    (i_dmem_wdata),
    .i_mask     (i_dmem_mask),
    .i_rd_idx   (idx),
    .i_rd_word  (rd_raw),
    .o_rd_word  (rd_word),
    .o_cmt_en   (wr_en),
    .o_cmt_idx  (wr_idx),
    .o_cmt_data (wr_data),
    .o_cmt_mask (wr_mask)
  );
`else
  // Direct write at the acceptance edge; a reset edge drops the store.
  assign wr_en   = st_acc & i_rst_n;
  assign wr_idx  = idx;
  assign wr_data = i_dmem_wdata;
  assign wr_mask = i_dmem_mask;
  assign rd_word = rd_raw;
`endif

  always_ff @(posedge i_clk) begin
    if (clr_we && i_rst_n) mem_q[clr_idx_q] <= '0;
    else if (wr_en)        mem_q[wr_idx] <= byte_merge(mem_q[wr_idx], wr_data, wr_mask);
  end

  assign o_dmem_rdata = (o_dmem_ready && i_dmem_ren && in_range) ? rd_word : '0;
  assign o_oob        = oob_q;

endmodule
